dmem_access_unit: RTL

//  Data-memory access stage directly downstream of the ALU: takes the ALU result as

---
 rtl/dmem_access_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: runs one load or store per instruction on a ready/ack bus,
// with lane steering, load extension, alignment faults and a bus timeout.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_alu_result,
    input  logic [31:0]           i_write_data,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_load_unsigned,
    output logic                  o_stall,
    output logic [31:0]           o_load_data,
    output logic                  o_load_valid,
    output logic                  o_misalign,
    output logic                  o_bus_err,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [31:0]           o_bus_wdata,
    output logic [3:0]            o_bus_be,
    input  logic [31:0]           i_bus_rdata,
    input  logic                  i_bus_ack
);

    // state | meaning
    // IDLE  | waiting for a load/store; faults are decided here
    // BUSY  | bus_req high, waiting for ack or timeout
    // DONE  | one-cycle completion, pulses out, pipeline released
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_bus_we;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [31:0]           r_bus_wdata;
    logic [3:0]            r_bus_be;
    logic [1:0]            r_size;
    logic [1:0]            r_lane;
    logic                  r_unsigned;
    logic [31:0]           r_load_data;
    logic                  r_load_valid;
    logic                  r_misalign;
    logic                  r_bus_err;

    logic                  w_access;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ext;

    assign w_access = i_mem_read | i_mem_write;

    always_comb begin
        w_fault = 1'b0;
        w_be    = 4'b0000;
        w_wdata = i_write_data;
        case (i_size)
            2'b00: begin
                w_be    = 4'b0001 << i_alu_result[1:0];
                w_wdata = {4{i_write_data[7:0]}};
            end
            2'b01: begin
                w_fault = i_alu_result[0];
                w_be    = 4'b0011 << {i_alu_result[1], 1'b0};
                w_wdata = {2{i_write_data[15:0]}};
            end
            2'b10: begin
                w_fault = (i_alu_result[1:0] != 2'b00);
                w_be    = 4'b1111;
            end
            default: w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = i_bus_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = i_bus_rdata[7:0];
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_size)
            2'b00:   w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = i_bus_rdata;
        endcase
    end

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign o_stall = i_rst_n & ((r_state == S_BUSY) | ((r_state == S_IDLE) & w_access));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_be     <= '0;
            r_size       <= '0;
            r_lane       <= '0;
            r_unsigned   <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_fault) begin
                            r_misalign <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_bus_we    <= i_mem_write;
                            r_bus_addr  <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_size      <= i_size;
                            r_lane      <= i_alu_result[1:0];
                            r_unsigned  <= i_load_unsigned;
                            r_cnt       <= '0;
                            r_state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack in the final counted cycle still completes the access.
                    if (i_bus_ack) begin
                        if (!r_bus_we) begin
                            r_load_data  <= w_ext;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        if (!r_bus_we) begin
                            r_load_data <= '0;
                        end
                        r_bus_err <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bus_req    = (r_state == S_BUSY);
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_bus_be     = r_bus_be;
    assign o_load_data  = r_load_data;
    assign o_load_valid = r_load_valid;
    assign o_misalign   = r_misalign;
    assign o_bus_err    = r_bus_err;

endmodule
